// File: rtl/alu_secuencial.sv
// alu_secuencial: multicycle ALU for the multicycle datapath.
// Operands and the 4-bit ALU control code are captured on a start pulse.
// Non-shift operations complete in one cycle. Shifts run bit-serially,
// one bit per cycle. Completion is reported with a one-cycle done pulse
// together with a registered result and zero flag.
module alu_secuencial #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             zero
);

  // ALU control codes produced by the ALU control decoder
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0111;  // also BEQ
  localparam logic [3:0] OP_BNE  = 4'b1111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0110;

  localparam logic [SHW-1:0]   CNT_ZERO = SHW'(0);
  localparam logic [SHW-1:0]   CNT_ONE  = SHW'(1);
  localparam logic [WIDTH-1:0] DATA_ZERO = WIDTH'(0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // Helper functions
  // ------------------------------------------------------------------

  // True for the three codes that go through the bit-serial shifter
  function automatic logic is_shift_op(input logic [3:0] op);
    logic res;
    case (op)
      OP_SLL:  res = 1'b1;
      OP_SRL:  res = 1'b1;
      OP_SRA:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Single-cycle result. Shift codes only reach this path with a zero
  // shift amount, in which case the result is operand A unchanged.
  function automatic logic [WIDTH-1:0] alu_eval(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    logic             lt_signed;
    logic             lt_unsigned;
    lt_signed   = ($signed(a) < $signed(b));
    lt_unsigned = (a < b);
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_BNE:  res = a - b;
      OP_SLL:  res = a;
      OP_SRL:  res = a;
      OP_SRA:  res = a;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_LUI:  res = b;
      default: res = DATA_ZERO;
    endcase
    return res;
  endfunction

  // One step of the serial shifter in the direction/fill of the code.
  // SRA replicates the current MSB, which is still A's sign bit.
  function automatic logic [WIDTH-1:0] shift_by_one(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] v
  );
    logic [WIDTH-1:0] res;
    case (op)
      OP_SLL:  res = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  res = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  res = {v[WIDTH-1], v[WIDTH-1:1]};
      default: res = v;
    endcase
    return res;
  endfunction

  // Branch flag: BNE inverts the sense so the control unit can branch
  // on zero for both BEQ and BNE.
  function automatic logic zero_flag(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] res
  );
    logic flag;
    if (op == OP_BNE) begin
      flag = (res != DATA_ZERO);
    end else begin
      flag = (res == DATA_ZERO);
    end
    return flag;
  endfunction

  // ------------------------------------------------------------------
  // State and datapath registers
  // ------------------------------------------------------------------
  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] acc_s;
  logic [SHW-1:0]   cnt_r;
  logic [SHW-1:0]   cnt_s;
  logic [3:0]       op_r;
  logic [3:0]       op_s;

  logic             busy_s;
  logic             done_s;
  logic [WIDTH-1:0] res_s;
  logic             zero_s;

  logic [SHW-1:0]   shamt_s;
  logic             launch_shift_s;
  logic [WIDTH-1:0] idle_res_s;
  logic [WIDTH-1:0] step_s;

  assign shamt_s        = B[SHW-1:0];
  assign launch_shift_s = is_shift_op(ALUctrl) && (shamt_s != CNT_ZERO);
  assign idle_res_s     = alu_eval(ALUctrl, A, B);
  assign step_s         = shift_by_one(op_r, acc_r);

  // FSM state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    res_s   = resultado;
    zero_s  = zero;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (launch_shift_s) begin
            acc_s   = A;
            cnt_s   = shamt_s;
            op_s    = ALUctrl;
            busy_s  = 1'b1;
            state_s = ST_SHIFT;
          end else begin
            res_s   = idle_res_s;
            zero_s  = zero_flag(ALUctrl, idle_res_s);
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_s = step_s;
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          res_s   = step_s;
          zero_s  = zero_flag(op_r, step_s);
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; reset clears everything and aborts a shift
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r     <= DATA_ZERO;
      cnt_r     <= CNT_ZERO;
      op_r      <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      resultado <= DATA_ZERO;
      zero      <= 1'b0;
    end else begin
      acc_r     <= acc_s;
      cnt_r     <= cnt_s;
      op_r      <= op_s;
      busy      <= busy_s;
      done      <= done_s;
      resultado <= res_s;
      zero      <= zero_s;
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_secuencial;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUctrl;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] resultado;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_secuencial #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ALUctrl   (ALUctrl),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference result from the operation table
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (op)
      4'b0000: return a + b;
      4'b0111: return a - b;
      4'b1111: return a - b;
      4'b1000: return a << sh;
      4'b1010: return a >> sh;
      4'b1110: return 32'($signed(a) >>> sh);
      4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return (a < b) ? 32'd1 : 32'd0;
      4'b1001: return a ^ b;
      4'b0001: return a | b;
      4'b0010: return a & b;
      4'b0110: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_zero(input logic [3:0] op, input logic [31:0] r);
    return (op == 4'b1111) ? (r != 32'd0) : (r == 32'd0);
  endfunction

  // Cycle (counted from the start cycle) in which done is expected
  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    bit is_shift;
    is_shift = (op == 4'b1000) || (op == 4'b1010) || (op == 4'b1110);
    return (is_shift && (b[4:0] != 5'd0)) ? int'(b[4:0]) + 1 : 1;
  endfunction

  // Issue one operation from a negedge and check busy/done every cycle
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          lat;
    logic [31:0] er;
    lat = ref_latency(op, b);
    er  = ref_result(op, a, b);
    start   = 1'b1;
    ALUctrl = op;
    A       = a;
    B       = b;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    A       = $urandom;
    B       = $urandom;
    ALUctrl = 4'($urandom);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      check_eq($sformatf("busy op%b c%0d", op, k), 32'(busy), 32'(k < lat));
      check_eq($sformatf("done op%b c%0d", op, k), 32'(done), 32'(k == lat));
    end
    check_eq($sformatf("resultado op%b", op), resultado, er);
    check_eq($sformatf("zero op%b", op), 32'(zero), 32'(ref_zero(op, er)));
    @(negedge clk);
    check_eq("done_single_pulse", 32'(done), 32'd0);
    check_eq("resultado_hold", resultado, er);
  endtask

  logic [3:0]  nonshift_ops [9] = '{4'b0000, 4'b0111, 4'b1111, 4'b0100, 4'b1100,
                                    4'b1001, 4'b0001, 4'b0010, 4'b0110};

  initial begin
    int          dones;
    int          done_cycle;
    logic [31:0] done_res;
    logic [31:0] sa;
    logic [3:0]  bop [4];
    logic [31:0] ba  [4];
    logic [31:0] bb  [4];

    reset   = 1'b1;
    start   = 1'b0;
    ALUctrl = 4'b0000;
    A       = 32'd0;
    B       = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_resultado", resultado, 32'd0);
    check_eq("rst_zero", 32'(zero), 32'd0);
    reset = 1'b0;

    // Directed cases from the operation table
    run_op(4'b0000, 32'hFFFFFFFF, 32'd1);
    run_op(4'b0111, 32'd5, 32'd7);
    run_op(4'b0111, 32'h1234, 32'h1234);
    run_op(4'b1111, 32'h1234, 32'h1234);
    run_op(4'b1111, 32'd1, 32'd2);
    run_op(4'b1000, 32'h80000001, 32'd4);
    run_op(4'b1010, 32'h80000001, 32'd4);
    run_op(4'b1110, 32'h80000001, 32'd4);
    run_op(4'b1000, 32'h80000001, 32'h20);
    run_op(4'b0100, 32'hFFFFFFFF, 32'd1);
    run_op(4'b1100, 32'hFFFFFFFF, 32'd1);
    run_op(4'b1001, 32'hF0F0F0F0, 32'h0FF00FF0);
    run_op(4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0);
    run_op(4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0);
    run_op(4'b0110, 32'h12345678, 32'hABCDE000);
    run_op(4'b0011, 32'h12345678, 32'h9ABCDEF0);

    // Busy protection: a start during a long shift is ignored
    sa      = $urandom | 32'h1;
    start   = 1'b1;
    ALUctrl = 4'b1000;
    A       = sa;
    B       = 32'd31;
    @(posedge clk);
    @(negedge clk);
    start      = 1'b0;
    dones      = 0;
    done_cycle = 0;
    done_res   = 32'd0;
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) @(negedge clk);
      check_eq($sformatf("prot_busy c%0d", k), 32'(busy), 32'(k <= 31));
      if (done) begin
        dones++;
        done_cycle = k;
        done_res   = resultado;
      end
      if (k == 10) begin
        start   = 1'b1;
        ALUctrl = 4'b0000;
        A       = 32'd1;
        B       = 32'd2;
      end else if (k == 11) begin
        start = 1'b0;
      end
    end
    check_eq("prot_done_count", 32'(dones), 32'd1);
    check_eq("prot_done_cycle", 32'(done_cycle), 32'd32);
    check_eq("prot_result", done_res, sa << 31);

    // Reset in the middle of a shift aborts it without a done
    start   = 1'b1;
    ALUctrl = 4'b1010;
    A       = 32'h80000001;
    B       = 32'd20;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_resultado", resultado, 32'd0);
    check_eq("midrst_zero", 32'(zero), 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("midrst_no_done", 32'(dones), 32'd0);
    run_op(4'b0000, 32'd100, 32'd23);

    // Reset and start at the same edge: reset wins
    reset   = 1'b1;
    start   = 1'b1;
    ALUctrl = 4'b0000;
    A       = 32'd3;
    B       = 32'd4;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_eq("rst_start_done", 32'(done), 32'd0);
    check_eq("rst_start_res", resultado, 32'd0);
    @(negedge clk);
    check_eq("rst_start_done2", 32'(done), 32'd0);

    // start held high: a new single-cycle operation every cycle
    for (int i = 0; i < 4; i++) begin
      bop[i] = nonshift_ops[$urandom_range(0, 8)];
      ba[i]  = $urandom;
      bb[i]  = $urandom;
    end
    start   = 1'b1;
    ALUctrl = bop[0];
    A       = ba[0];
    B       = bb[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("b2b_done %0d", i), 32'(done), 32'd1);
      check_eq($sformatf("b2b_res %0d", i), resultado, ref_result(bop[i], ba[i], bb[i]));
      check_eq($sformatf("b2b_zero %0d", i), 32'(zero),
               32'(ref_zero(bop[i], ref_result(bop[i], ba[i], bb[i]))));
      if (i < 3) begin
        ALUctrl = bop[i+1];
        A       = ba[i+1];
        B       = bb[i+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
